// File: rtl/unified_mem_ctrl.sv
// Single-port unified instruction/data memory: data accesses win the port,
// fetch stalls on conflict, reads are registered, sub-word loads/stores extend.
module unified_mem_ctrl #(
  parameter int DEPTH     = 128,
  parameter int DATA_BASE = 64,
  parameter int ADDR_W    = 8,
  parameter int PROG_N    = 1,
  parameter logic [PROG_N*32-1:0] PROG_INIT = '0,
  parameter int DATA_N    = 1,
  parameter logic [DATA_N*32-1:0] DATA_INIT = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_valid,
  output logic              stall_if,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [2:0]        d_funct3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_valid,
  output logic              d_misalign
);
  localparam int IDX_W = $clog2(DEPTH);
  typedef logic [31:0] mem_t [DEPTH];

  function automatic mem_t mem_init();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) m[IDX_W'(i)] = '0;
    for (int i = 0; i < PROG_N; i++) m[IDX_W'(i % DEPTH)] = PROG_INIT[i*32 +: 32];
    for (int i = 0; i < DATA_N; i++) m[IDX_W'((DATA_BASE + i) % DEPTH)] = DATA_INIT[i*32 +: 32];
    return m;
  endfunction

  // Preloaded image; deliberately untouched by reset.
  mem_t mem_q = mem_init();

  logic [IDX_W-1:0] if_idx, d_idx;
  logic [31:0] d_word, ld_val, wmask, wdata_sh, mem_wr;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic        d_req, if_gnt, f3_ok, aligned, bad, we;
  logic [31:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic        if_valid_q, if_valid_d, d_valid_q, d_valid_d, d_misalign_q, d_misalign_d;

  always_comb begin
    if_idx   = IDX_W'(if_addr >> 2);
    d_idx    = IDX_W'(DATA_BASE) + IDX_W'(d_addr >> 2);
    d_req    = d_read | d_write;
    if_gnt   = if_req & ~d_req;
    stall_if = if_req & d_req;

    f3_ok   = 1'b1;
    aligned = 1'b1;
    case (d_funct3)
      3'b000: ;
      3'b001: aligned = ~d_addr[0];
      3'b010: aligned = (d_addr[1:0] == 2'b00);
      3'b100: f3_ok = ~d_write;
      3'b101: begin f3_ok = ~d_write; aligned = ~d_addr[0]; end
      default: f3_ok = 1'b0;
    endcase
    bad = d_req & ~(f3_ok & aligned);
    // A simultaneous read+write is treated as a store only.
    we  = d_write & ~bad;

    d_word = mem_q[d_idx];
    ld_b   = d_word[{d_addr[1:0], 3'b000} +: 8];
    ld_h   = d_addr[1] ? d_word[31:16] : d_word[15:0];
    case (d_funct3)
      3'b000:  ld_val = {{24{ld_b[7]}}, ld_b};
      3'b001:  ld_val = {{16{ld_h[15]}}, ld_h};
      3'b100:  ld_val = {24'd0, ld_b};
      3'b101:  ld_val = {16'd0, ld_h};
      default: ld_val = d_word;
    endcase

    case (d_funct3[1:0])
      2'b00: begin
        wmask    = 32'h0000_00FF << {d_addr[1:0], 3'b000};
        wdata_sh = {4{d_wdata[7:0]}};
      end
      2'b01: begin
        wmask    = d_addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        wdata_sh = {2{d_wdata[15:0]}};
      end
      default: begin
        wmask    = 32'hFFFF_FFFF;
        wdata_sh = d_wdata;
      end
    endcase
    mem_wr = (d_word & ~wmask) | (wdata_sh & wmask);

    if_valid_d   = if_gnt;
    if_rdata_d   = if_gnt ? mem_q[if_idx] : if_rdata_q;
    d_valid_d    = d_read & ~d_write & ~bad;
    d_rdata_d    = d_valid_d ? ld_val : d_rdata_q;
    d_misalign_d = bad;
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[d_idx] <= mem_wr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata_q   <= '0;
      if_valid_q   <= 1'b0;
      d_rdata_q    <= '0;
      d_valid_q    <= 1'b0;
      d_misalign_q <= 1'b0;
    end else begin
      if_rdata_q   <= if_rdata_d;
      if_valid_q   <= if_valid_d;
      d_rdata_q    <= d_rdata_d;
      d_valid_q    <= d_valid_d;
      d_misalign_q <= d_misalign_d;
    end
  end

  assign if_rdata   = if_rdata_q;
  assign if_valid   = if_valid_q;
  assign d_rdata    = d_rdata_q;
  assign d_valid    = d_valid_q;
  assign d_misalign = d_misalign_q;
endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Bench for unified_mem_ctrl: byte-array reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_unified_mem_ctrl;
  localparam int DEPTH = 128;
  localparam int DBASE = 100;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [31:0]   if_rdata;
  logic          if_valid, stall_if;
  logic          d_read, d_write;
  logic [2:0]    d_funct3;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata, d_rdata;
  logic          d_valid, d_misalign;

  int total = 0;
  int bad   = 0;

  unified_mem_ctrl #(
    .DEPTH(DEPTH), .DATA_BASE(DBASE), .ADDR_W(AW),
    .PROG_N(2), .PROG_INIT({32'h2222_2222, 32'h1111_1111}),
    .DATA_N(2), .DATA_INIT({32'h0000_0009, 32'h8000_7F81})
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .stall_if(stall_if),
    .d_read(d_read), .d_write(d_write), .d_funct3(d_funct3),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_valid(d_valid), .d_misalign(d_misalign)
  );

  always #5 clk = ~clk;

  // Reference model: memory as a flat byte array.
  logic [7:0]  mb [DEPTH*4];
  logic        e_ifv, e_dv, e_mis;
  logic [31:0] e_ifr, e_dr;
  logic        n_ifv, n_dv, n_mis;
  logic [31:0] n_ifr, n_dr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mword(input int wi);
    return {mb[wi*4+3], mb[wi*4+2], mb[wi*4+1], mb[wi*4]};
  endfunction

  task automatic model_eval();
    int sz, wi, ba;
    bit legal;
    logic [31:0] v;
    n_ifv = 1'b0; n_ifr = e_ifr; n_dv = 1'b0; n_dr = e_dr; n_mis = 1'b0;
    if (if_req && !(d_read || d_write)) begin
      n_ifv = 1'b1;
      n_ifr = mword((int'(if_addr) / 4) % DEPTH);
    end
    if (d_read || d_write) begin
      case (d_funct3)
        3'd0, 3'd4: sz = 1;
        3'd1, 3'd5: sz = 2;
        3'd2:       sz = 4;
        default:    sz = 0;
      endcase
      legal = (sz != 0) && !(d_write && d_funct3[2]);
      if (!legal || (int'(d_addr) % sz) != 0) n_mis = 1'b1;
      else begin
        wi = (DBASE + int'(d_addr) / 4) % DEPTH;
        ba = wi * 4 + int'(d_addr) % 4;
        if (d_write) begin
          for (int k = 0; k < sz; k++) mb[ba+k] = d_wdata[8*k +: 8];
        end else begin
          v = '0;
          for (int k = 0; k < sz; k++) v[8*k +: 8] = mb[ba+k];
          if (!d_funct3[2] && sz < 4 && v[8*sz-1])
            for (int k = sz; k < 4; k++) v[8*k +: 8] = 8'hFF;
          n_dv = 1'b1;
          n_dr = v;
        end
      end
    end
  endtask

  task automatic step();
    model_eval();
    @(posedge clk);
    e_ifv = n_ifv; e_ifr = n_ifr; e_dv = n_dv; e_dr = n_dr; e_mis = n_mis;
    #2;
  endtask

  task automatic idle();
    if_req = 0; if_addr = '0; d_read = 0; d_write = 0;
    d_funct3 = 3'd0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic dop(input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [AW-1:0] a, input logic [31:0] wd);
    d_read = rd; d_write = wr; d_funct3 = f3; d_addr = a; d_wdata = wd;
    step();
  endtask

  initial forever begin
    @(negedge clk);
    chk("if_valid", if_valid, e_ifv);
    chk("if_rdata", if_rdata, e_ifr);
    chk("d_valid", d_valid, e_dv);
    chk("d_rdata", d_rdata, e_dr);
    chk("d_misalign", d_misalign, e_mis);
    chk("stall_if", stall_if, if_req && (d_read || d_write));
  end

  initial begin
    for (int i = 0; i < DEPTH*4; i++) mb[i] = 8'h00;
    {mb[3], mb[2], mb[1], mb[0]} = 32'h1111_1111;
    {mb[7], mb[6], mb[5], mb[4]} = 32'h2222_2222;
    {mb[DBASE*4+3], mb[DBASE*4+2], mb[DBASE*4+1], mb[DBASE*4]} = 32'h8000_7F81;
    {mb[DBASE*4+7], mb[DBASE*4+6], mb[DBASE*4+5], mb[DBASE*4+4]} = 32'h0000_0009;
    e_ifv = 0; e_ifr = 0; e_dv = 0; e_dr = 0; e_mis = 0;
    idle();
    rst_n = 1'b0;
    #3;
    chk("rst if_valid", if_valid, 0);
    chk("rst if_rdata", if_rdata, 0);
    chk("rst d_valid", d_valid, 0);
    chk("rst d_rdata", d_rdata, 0);
    chk("rst d_misalign", d_misalign, 0);
    chk("rst stall_if", stall_if, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Back-to-back fetches
    if_req = 1; if_addr = 8'h00; step();
    chk("fetch0 valid", if_valid, 1); chk("fetch0 data", if_rdata, 32'h1111_1111);
    if_addr = 8'h04; step();
    chk("fetch1 valid", if_valid, 1); chk("fetch1 data", if_rdata, 32'h2222_2222);
    idle(); step();
    chk("fetch pulse", if_valid, 0);

    // Sub-word loads with extension
    dop(1, 0, 3'b000, 8'd0, '0); chk("lb", d_rdata, 32'hFFFF_FF81);
    dop(1, 0, 3'b100, 8'd0, '0); chk("lbu", d_rdata, 32'h0000_0081);
    dop(1, 0, 3'b001, 8'd2, '0); chk("lh", d_rdata, 32'hFFFF_8000);
    dop(1, 0, 3'b101, 8'd2, '0); chk("lhu", d_rdata, 32'h0000_8000);

    // Partial stores
    dop(0, 1, 3'b000, 8'd5, 32'hDEAD_BEAB);
    dop(1, 0, 3'b010, 8'd4, '0); chk("sb then lw", d_rdata, 32'h0000_AB09);
    dop(0, 1, 3'b001, 8'd6, 32'hCAFE_1234);
    dop(1, 0, 3'b010, 8'd4, '0); chk("sh then lw", d_rdata, 32'h1234_AB09);

    // Fetch/data conflict
    if_req = 1; if_addr = 8'h08; d_read = 1; d_funct3 = 3'b010; d_addr = 8'd0;
    #1 chk("conflict stall", stall_if, 1);
    step();
    chk("conflict d_valid", d_valid, 1); chk("conflict d_rdata", d_rdata, 32'h8000_7F81);
    chk("conflict if_valid", if_valid, 0);
    d_read = 0; step();
    chk("refetch valid", if_valid, 1); chk("refetch data", if_rdata, 32'h0);
    idle();

    // Misaligned and illegal accesses are suppressed
    dop(1, 0, 3'b010, 8'd2, '0);
    chk("lw mis", d_misalign, 1); chk("lw mis valid", d_valid, 0);
    chk("lw mis hold", d_rdata, 32'h8000_7F81);
    dop(0, 1, 3'b001, 8'd3, 32'hFFFF_FFFF); chk("sh mis", d_misalign, 1);
    dop(1, 0, 3'b011, 8'd0, '0); chk("bad f3", d_misalign, 1);
    dop(0, 1, 3'b100, 8'd0, 32'h0); chk("store f3 4", d_misalign, 1);
    dop(1, 0, 3'b010, 8'd0, '0);
    chk("after mis", d_rdata, 32'h8000_7F81); chk("mis clear", d_misalign, 0);

    // Read+write together: store wins, no load response
    dop(1, 1, 3'b010, 8'd8, 32'h1234_5678); chk("rw valid", d_valid, 0);
    dop(1, 0, 3'b010, 8'd8, '0); chk("rw stored", d_rdata, 32'h1234_5678);

    // Reset mid-cycle after a sampled load
    dop(1, 0, 3'b010, 8'd4, '0);
    chk("pre-rst valid", d_valid, 1);
    rst_n = 1'b0; #1;
    e_ifv = 0; e_ifr = 0; e_dv = 0; e_dr = 0; e_mis = 0;
    chk("async rst valid", d_valid, 0); chk("async rst data", d_rdata, 0);
    idle(); step();
    rst_n = 1'b1;
    dop(1, 0, 3'b010, 8'd4, '0); chk("mem kept", d_rdata, 32'h1234_AB09);
    idle();

    // Randomized traffic; compare process checks every cycle
    for (int n = 0; n < 3000; n++) begin
      int r;
      if_req  = 1'($urandom % 2);
      if_addr = AW'($urandom % 256);
      r = int'($urandom % 8);
      d_read   = (r == 1 || r == 2 || r == 7);
      d_write  = (r == 3 || r == 4 || r == 7);
      d_funct3 = 3'($urandom % 8);
      d_addr   = ($urandom % 2 == 0) ? AW'($urandom % 16) : AW'($urandom % 256);
      d_wdata  = $urandom;
      step();
    end
    idle(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/unified_mem_ctrl.md
# unified_mem_ctrl

Parametrised single-port unified instruction/data memory for the pipelined RISC-V core, replacing the fixed 128-word combinational memory. It arbitrates the fetch and load/store ports onto one storage array, giving data accesses priority and stalling fetch on conflict. Reads are registered, and loads and stores handle byte, halfword and word funct3 encodings with sign/zero extension. Misaligned data accesses are detected and suppressed.

## Interface
Parameters:
- DEPTH, 128, total words in the array (power of two).
- DATA_BASE, 64, word index at which data byte address 0 maps.
- ADDR_W, 8, byte-address width of both ports.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; one clock, asynchronous, active-low.
- if_req  input  1  fetch request this cycle.
- if_addr  input  ADDR_W  fetch byte address; bits [1:0] ignored.
- if_rdata  output  32  fetched instruction, registered.
- if_valid  output  1  if_rdata holds the response to last cycle's granted fetch.
- stall_if  output  1  combinational; fetch not granted this cycle, hold PC and re-present the request.
- d_read  input  1  load request.
- d_write  input  1  store request.
- d_funct3  input  3  000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu (loads); 000 sb, 001 sh, 010 sw (stores).
- d_addr  input  ADDR_W  data byte address, relative to DATA_BASE.
- d_wdata  input  32  store data; the low byte/half/word is used.
- d_rdata  output  32  extended load result, registered.
- d_valid  output  1  d_rdata holds the response to last cycle's load.
- d_misalign  output  1  registered; last cycle's data access was misaligned or had an illegal funct3 and was suppressed.

## Operation
- Word index, fetch: (if_addr>>2) mod DEPTH.
- Word index, data: (DATA_BASE + (d_addr>>2)) mod DEPTH. Wrap-around is silent.
- Arbitration:
  - d_read or d_write owns the port. If if_req is also high, stall_if=1 and the fetch is not performed.
  - Otherwise a fetch is granted when if_req=1.
- d_read and d_write both high: the store is performed, the load is ignored, and d_valid=0 next cycle.
- Alignment:
  - lh/lhu/sh require d_addr[0]=0.
  - lw/sw require d_addr[1:0]=00.
  - Byte accesses are always aligned.
  - On violation or an undefined funct3, there is no array write, d_misalign=1 next cycle, d_valid=0, and d_rdata is held.
- Stores write only the addressed lanes: byte lane d_addr[1:0], halfword lane d_addr[1], or the full word. Other bytes are unchanged.
- Loads select the lane by d_addr[1:0]. lb/lh sign-extend, lbu/lhu zero-extend, lw returns the word.
- Array contents are not cleared by reset. Contents are preloaded at elaboration, with program words at index 0 and up and data at DATA_BASE and up.

## Timing
- Reset (rst_n=0, asynchronous): if_rdata=0, if_valid=0, d_rdata=0, d_valid=0, d_misalign=0. stall_if is combinational and is 0 when no data request is present.
- Granted fetch sampled at edge N: if_rdata/if_valid are updated at edge N and are valid during cycle N+1. if_valid is a single-cycle pulse per grant.
- Load sampled at edge N: d_rdata/d_valid are valid during cycle N+1, with 1-cycle latency. d_valid is 0 in cycles with no load.
- Store at edge N is committed by that edge. A load to the same word sampled at edge N+1 returns the new data, so there is no forwarding hazard.
- Ungranted fetch: if_valid=0 next cycle. The request is re-presented by the pipeline, and the controller does not queue it.
- Reset asserted mid-access: the pending response is discarded and outputs go to reset values immediately. A store sampled on the same edge that reset is asserted is not guaranteed.

## Test plan
- Reset, then if_req with if_addr=0x00, 0x04 in consecutive cycles -> if_valid pulses in the next cycles, with if_rdata = word0 then word1 and stall_if=0 throughout.
- Preload data word0 = 0x8000_7F81. Run lb, lbu, lh, lhu at d_addr 0, 0, 2, 2 -> d_rdata = 0xFFFF_FF81, 0x0000_0081, 0xFFFF_8000, 0x0000_8000, one cycle after each request.
- sb 0xAB to d_addr 5, then lw at 4 with data word1 initially 9 -> 0x0000_AB09. sh 0x1234 to d_addr 6, then lw at 4 -> 0x1234_AB09.
- if_req and d_read high in the same cycle -> stall_if=1 that cycle, d_valid=1 next cycle, if_valid=0 next cycle. Re-presented fetch -> if_valid=1 one cycle later.
- lw at d_addr 2, then sh at d_addr 3 -> d_misalign=1 for each, d_valid=0, and the array is unchanged (verified by a later lw at 0).
- Assert rst_n=0 mid-cycle after a load is sampled -> d_valid and d_rdata drop to 0 immediately, without waiting for a clock edge.
